// File: rtl/nios_mul_share_arbiter.sv
// nios_mul_share_arbiter: time-shares one registered 32x32 multiplier between two requesters,
// steering each result into a per-requester response register with valid/ready backpressure.
module nios_mul_share_arbiter #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_src1,
    input  logic [31:0] req0_src2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_src1,
    input  logic [31:0] req1_src2,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    input  logic [31:0] mul_result
);
    logic             last_grant_q, last_grant_d;
    logic             inflight_valid_q, inflight_valid_d;
    logic             inflight_id_q, inflight_id_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0][31:0] rsp_result_q, rsp_result_d;
    logic [1:0]       cap, rsp_ready, elig, grant;

    always_comb begin
        rsp_ready = {rsp1_ready, rsp0_ready};
        cap = {inflight_valid_q & inflight_id_q, inflight_valid_q & ~inflight_id_q};
        // Own op in flight or an undrained response blocks a requester; reset masks all grants.
        elig = {req1_valid, req0_valid} & ~cap & (~rsp_valid_q | rsp_ready) & {2{reset_n}};
        grant = (elig == 2'b11) ? ((RR_ENABLE && !last_grant_q) ? 2'b10 : 2'b01) : elig;
        mul_src1 = grant[1] ? req1_src1 : grant[0] ? req0_src1 : 32'h0;
        mul_src2 = grant[1] ? req1_src2 : grant[0] ? req0_src2 : 32'h0;
        inflight_valid_d = |grant;
        inflight_id_d = |grant ? grant[1] : inflight_id_q;
        last_grant_d = |grant ? grant[1] : last_grant_q;
        rsp_valid_d = cap | (rsp_valid_q & ~rsp_ready);
        rsp_result_d[0] = cap[0] ? mul_result : rsp_result_q[0];
        rsp_result_d[1] = cap[1] ? mul_result : rsp_result_q[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q     <= 1'b1;
            inflight_valid_q <= 1'b0;
            inflight_id_q    <= 1'b0;
            rsp_valid_q      <= '0;
            rsp_result_q     <= '0;
        end else begin
            last_grant_q     <= last_grant_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_id_q    <= inflight_id_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_result_q     <= rsp_result_d;
        end
    end

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp0_result = rsp_result_q[0];
    assign rsp1_result = rsp_result_q[1];
endmodule

// File: tb/tb_nios_mul_share_arbiter.sv
// tb_nios_mul_share_arbiter: directed vectors with a result scoreboard; a round-robin and a
// fixed-priority instance share the same stimulus.
module tb_nios_mul_share_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result, mul_src1, mul_src2, mul_res;
    logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid;
    logic [31:0] f_rsp0_result, f_rsp1_result, f_mul_src1, f_mul_src2, f_mul_res;
    logic [31:0] exp0, exp1;
    logic [31:0] q0[$], q1[$];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    nios_mul_share_arbiter #(.RR_ENABLE(1'b1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1), .req1_src2(req1_src2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_res)
    );

    nios_mul_share_arbiter #(.RR_ENABLE(1'b0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_src1(req1_src1), .req1_src2(req1_src2),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(f_rsp0_result),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(f_rsp1_result),
        .mul_src1(f_mul_src1), .mul_src2(f_mul_src2), .mul_result(f_mul_res)
    );

    // Multiplier cells: one registered stage.
    always @(posedge clk) begin
        mul_res   <= mul_src1 * mul_src2;
        f_mul_res <= f_mul_src1 * f_mul_src2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue side: each accepted op pushes its hand-computed product; reset discards everything.
    always @(negedge clk) begin
        if (!reset_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (req0_valid && req0_ready) q0.push_back(exp0);
            if (req1_valid && req1_ready) q1.push_back(exp1);
        end
    end

    // Response side: every delivered result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) chk("rsp0_unexpected", rsp0_result, 32'hxxxx_xxxx);
                else chk("rsp0_result", rsp0_result, q0.pop_front());
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) chk("rsp1_unexpected", rsp1_result, 32'hxxxx_xxxx);
                else chk("rsp1_result", rsp1_result, q1.pop_front());
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b1; req0_src1 = 32'd5; req0_src2 = 32'd5; exp0 = 32'd25;
        req1_valid = 1'b0; req1_src1 = 32'd0; req1_src2 = 32'd0; exp1 = 32'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_f_req0_ready", {31'd0, f_req0_ready}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_rsp0_result", rsp0_result, 32'd0);
        chk("rst_mul_src1", mul_src1, 32'd0);
        chk("rst_mul_src2", mul_src2, 32'd0);
        tick();
        // Single op, granted in the first cycle after release.
        reset_n = 1'b1;
        req0_src1 = 32'd7; req0_src2 = 32'd6; exp0 = 32'd42; rsp0_ready = 1'b1;
        @(negedge clk);
        chk("single_ready", {31'd0, req0_ready}, 32'd1);
        chk("single_f_ready", {31'd0, f_req0_ready}, 32'd1);
        chk("single_mul_src1", mul_src1, 32'd7);
        chk("single_mul_src2", mul_src2, 32'd6);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("single_n1_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("idle_mul_src1", mul_src1, 32'd0);
        tick();
        @(negedge clk);
        chk("single_n2_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("single_n2_result", rsp0_result, 32'd42);
        tick();
        @(negedge clk);
        chk("single_n3_valid", {31'd0, rsp0_valid}, 32'd0);
        tick();
        // Contention: last grant was requester 0, so round-robin starts with 1, fixed priority with 0.
        req0_valid = 1'b1; req0_src1 = 32'h0001_0000; req0_src2 = 32'h0001_0000; exp0 = 32'h0;
        req1_valid = 1'b1; req1_src1 = 32'hFFFF_FFFF; req1_src2 = 32'd2; exp1 = 32'hFFFF_FFFE;
        rsp1_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant1", {31'd0, req1_ready}, {31'd0, k % 2 == 0});
            chk("rr_grant0", {31'd0, req0_ready}, {31'd0, k % 2 == 1});
            chk("fp_grant0", {31'd0, f_req0_ready}, {31'd0, k % 2 == 0});
            chk("fp_grant1", {31'd0, f_req1_ready}, {31'd0, k % 2 == 1});
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) tick();
        // Backpressure on requester 1; requester 0 keeps flowing.
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_src1 = 32'h1234_5678; req1_src2 = 32'h10; exp1 = 32'h2345_6780;
        @(negedge clk);
        chk("bp_first_grant", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_src1 = 32'h1111_1111; req1_src2 = 32'hF; exp1 = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("bp_inflight_block", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b1; req0_src1 = 32'd100; req0_src2 = 32'd100; exp0 = 32'd10000;
        @(negedge clk);
        chk("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("bp_rsp1_result", rsp1_result, 32'h2345_6780);
        chk("bp_other_granted", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_stalled", {31'd0, req1_ready}, 32'd0);
            chk("bp_held", rsp1_result, 32'h2345_6780);
            tick();
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("bp_regrant", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        repeat (3) tick();
        // Drain and regrant in the same cycle for requester 0.
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_src1 = 32'd2; req0_src2 = 32'd4; exp0 = 32'd8;
        @(negedge clk);
        chk("dr_grant", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("dr_held_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("dr_held_result", rsp0_result, 32'd8);
        tick();
        req0_valid = 1'b1; req0_src1 = 32'd3; req0_src2 = 32'd5; exp0 = 32'd15; rsp0_ready = 1'b1;
        @(negedge clk);
        chk("dr_regrant", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("dr_gap_valid", {31'd0, rsp0_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("dr_new_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("dr_new_result", rsp0_result, 32'd15);
        tick();
        // Reset one cycle after granting 9*9: the product must never appear.
        req0_valid = 1'b1; req0_src1 = 32'd9; req0_src2 = 32'd9; exp0 = 32'd81;
        @(negedge clk);
        chk("rm_grant", {31'd0, req0_ready}, 32'd1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rm_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rm_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rm_mul_src1", mul_src1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rm_no_result", {31'd0, rsp0_valid}, 32'd0);
            tick();
        end
        for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) tick();
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
